spi_slave: RTL and testbench

- SPI peripheral-side (slave) controller, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- Counterpart to the team's SPI master. Connects to the same host register bus style: 1-bit address, chip select, write enable, 8-bit data in and out.
- Samples the external SCK, SS and MOSI pins with i_clk. Exposes one RX holding register and one TX buffer register to the host, plus status flags and an interrupt.

---
 rtl/spi_slave.sv | 164 ++++++++++++++++
 tb/tb_spi_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 peripheral controller: 8-bit MSB-first frames, host register
// port with RX holding register, TX buffer, status flags and level interrupt.
module spi_slave (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_addr,
  input  logic       i_cs,
  input  logic       i_we,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic       i_sck,
  input  logic       i_ss,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic       o_irq
);

  localparam int unsigned FrameW = 8;
  localparam int unsigned CntW   = 3;

  typedef enum logic {IDLE, SHIFT} state_t;

  // [0],[1] synchronizer stages, [2] history for edge detection.
  // Left out of reset so a pin held low through reset never looks like a fresh edge.
  logic [2:0] sck_sync;
  logic [2:0] ss_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge i_clk) begin
    sck_sync  <= {sck_sync[1:0], i_sck};
    ss_sync   <= {ss_sync[1:0], i_ss};
    mosi_sync <= {mosi_sync[0], i_mosi};
  end

  logic sck_rise, sck_fall, ss_fall, ss_rise, mosi_bit;
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign ss_fall  = ~ss_sync[1] & ss_sync[2];
  assign ss_rise  = ss_sync[1] & ~ss_sync[2];
  assign mosi_bit = mosi_sync[1];

  state_t              state_q, state_d;
  logic [FrameW-1:0]   tx_buf_q, tx_buf_d;
  logic [FrameW-1:0]   tx_shift_q, tx_shift_d;
  logic [FrameW-1:0]   rx_shift_q, rx_shift_d;
  logic [FrameW-1:0]   rx_data_q, rx_data_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rx_full_q, rx_full_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic                ien_q, ien_d;
  logic                active;
  logic                do_load;
  logic                rd_data, wr_ctl, wr_data;

  assign active  = (state_q == SHIFT);
  assign rd_data = i_cs & ~i_we & i_addr;
  assign wr_ctl  = i_cs & i_we & ~i_addr;
  assign wr_data = i_cs & i_we & i_addr;

  // Next-state and datapath; bus clears come first so frame events override them.
  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    tx_valid_d = tx_valid_q;
    rx_full_d  = rx_full_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    ien_d      = ien_q;
    do_load    = 1'b0;

    if (rd_data) rx_full_d = 1'b0;
    if (wr_ctl) begin
      ien_d = i_dat[4];
      if (i_dat[2]) overrun_d  = 1'b0;
      if (i_dat[3]) underrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          do_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[FrameW-2:0], mosi_bit};
          bit_cnt_d  = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(FrameW - 1)) begin
            rx_data_d = {rx_shift_q[FrameW-2:0], mosi_bit};
            rx_full_d = 1'b1;
            if (rx_full_q && !rd_data) overrun_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[FrameW-2:0], 1'b0};
          else                 do_load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_load) begin
      if (tx_valid_q) begin
        tx_shift_d = tx_buf_q;
        tx_valid_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // A same-cycle host write lands after the load has taken the old buffer.
    if (wr_data) begin
      tx_buf_d   = i_dat;
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      tx_buf_q   <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      ien_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_valid_q <= tx_valid_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      ien_q      <= ien_d;
    end
  end

  assign o_dat     = i_addr ? rx_data_q
                            : {active, 2'b00, ien_q, underrun_q, overrun_q, ~tx_valid_q, rx_full_q};
  assign o_miso    = active ? tx_shift_q[FrameW-1] : 1'b0;
  assign o_miso_oe = active;
  assign o_irq     = ien_q & rx_full_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives SPI pins as a mode-0 master at 1/16 of
// i_clk and checks MISO data, host registers, flags and interrupt.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_addr = 1'b0;
  logic       i_cs = 1'b0;
  logic       i_we = 1'b0;
  logic [7:0] i_dat = 8'h00;
  logic [7:0] o_dat;
  logic       i_sck = 1'b0;
  logic       i_ss = 1'b1;
  logic       i_mosi = 1'b0;
  logic       o_miso;
  logic       o_miso_oe;
  logic       o_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_slave dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_addr    (i_addr),
    .i_cs      (i_cs),
    .i_we      (i_we),
    .i_dat     (i_dat),
    .o_dat     (o_dat),
    .i_sck     (i_sck),
    .i_ss      (i_ss),
    .i_mosi    (i_mosi),
    .o_miso    (o_miso),
    .o_miso_oe (o_miso_oe),
    .o_irq     (o_irq)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_dat = d;
    @(negedge clk);
    i_cs = 1'b0; i_we = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    i_cs = 1'b1; i_we = 1'b0; i_addr = a;
    #1 d = o_dat;
    @(negedge clk);
    i_cs = 1'b0;
  endtask

  task automatic ss_start();
    @(negedge clk);
    i_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_end();
    repeat (8) @(negedge clk);
    i_ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // One SCK pulse; MISO is captured right as SCK rises, like a mode-0 master.
  task automatic spi_bit(input logic b, output logic m);
    i_mosi = b;
    repeat (8) @(negedge clk);
    m = o_miso;
    i_sck = 1'b1;
    repeat (8) @(negedge clk);
    i_sck = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  // Full byte whose 8th rising-edge strobe coincides with a host read of addr1.
  task automatic xfer_read_at_end(input logic [7:0] tx, output logic [7:0] rd);
    logic m;
    for (int i = 7; i >= 1; i--) spi_bit(tx[i], m);
    i_mosi = tx[0];
    repeat (8) @(negedge clk);
    i_sck = 1'b1;
    repeat (2) @(negedge clk);
    i_cs = 1'b1; i_we = 1'b0; i_addr = 1'b1;
    #1 rd = o_dat;
    @(negedge clk);
    i_cs = 1'b0;
    repeat (5) @(negedge clk);
    i_sck = 1'b0;
  endtask

  initial begin
    logic [7:0] rd, mo;
    logic       m;

    repeat (4) @(negedge clk);
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    bus_read(1'b0, rd); chk("reset_status", rd, 8'h02);
    bus_read(1'b1, rd); chk("reset_rxdata", rd, 8'h00);
    chk("reset_oe", 8'(o_miso_oe), 8'h00);
    chk("reset_irq", 8'(o_irq), 8'h00);
    chk("reset_miso", 8'(o_miso), 8'h00);

    // single byte frame
    bus_write(1'b1, 8'hA5);
    bus_write(1'b0, 8'h10);
    bus_read(1'b0, rd); chk("t1_status_pre", rd, 8'h10);
    ss_start();
    bus_read(1'b0, rd); chk("t1_status_active", rd, 8'h92);
    chk("t1_oe", 8'(o_miso_oe), 8'h01);
    xfer(8'h3C, mo);   chk("t1_miso", mo, 8'hA5);
    ss_end();
    chk("t1_irq_set", 8'(o_irq), 8'h01);
    bus_read(1'b0, rd); chk("t1_status_post", rd, 8'h1B);
    bus_read(1'b1, rd); chk("t1_rxdata", rd, 8'h3C);
    chk("t1_irq_clr", 8'(o_irq), 8'h00);
    bus_read(1'b0, rd); chk("t1_status_clr", rd, 8'h1A);
    bus_write(1'b0, 8'h18);
    bus_read(1'b0, rd); chk("t1_underrun_w1c", rd, 8'h12);

    // two bytes in one frame, buffer refilled mid-byte
    bus_write(1'b1, 8'h11);
    ss_start();
    bus_write(1'b1, 8'h22);
    xfer(8'hF0, mo);   chk("t2_miso_b1", mo, 8'h11);
    bus_read(1'b0, rd); chk("t2_rxfull_b1", rd & 8'h01, 8'h01);
    xfer(8'h0F, mo);   chk("t2_miso_b2", mo, 8'h22);
    ss_end();
    bus_read(1'b0, rd); chk("t2_status", rd, 8'h1F);
    bus_read(1'b1, rd); chk("t2_rxdata", rd, 8'h0F);
    bus_write(1'b0, 8'h1C);
    bus_read(1'b0, rd); chk("t2_flags_clr", rd, 8'h12);

    // frame started with empty buffer
    ss_start();
    xfer(8'h55, mo);   chk("t3_miso_zero", mo, 8'h00);
    ss_end();
    bus_read(1'b0, rd); chk("t3_status", rd, 8'h1B);
    bus_write(1'b0, 8'h08);
    bus_read(1'b0, rd); chk("t3_underrun_clr", rd, 8'h03);
    bus_read(1'b1, rd); chk("t3_rxdata", rd, 8'h55);
    bus_write(1'b0, 8'h10);

    // aborted frame after 5 pulses, then a full frame
    bus_write(1'b1, 8'h99);
    ss_start();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, m);
    ss_end();
    bus_read(1'b0, rd); chk("t4_partial_status", rd, 8'h12);
    bus_write(1'b1, 8'h7E);
    ss_start();
    xfer(8'h81, mo);   chk("t4_miso", mo, 8'h7E);
    ss_end();
    bus_read(1'b0, rd); chk("t4_status", rd, 8'h1B);
    bus_read(1'b1, rd); chk("t4_rxdata", rd, 8'h81);
    bus_write(1'b0, 8'h18);

    // reset in the middle of a frame
    bus_write(1'b1, 8'h5A);
    ss_start();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    @(negedge clk); i_reset = 1'b1;
    repeat (2) @(negedge clk); i_reset = 1'b0;
    chk("t5_oe_after_reset", 8'(o_miso_oe), 8'h00);
    bus_read(1'b0, rd); chk("t5_status_reset", rd, 8'h02);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    repeat (8) @(negedge clk);
    bus_read(1'b0, rd); chk("t5_sck_ignored", rd, 8'h02);
    bus_read(1'b1, rd); chk("t5_rxdata", rd, 8'h00);
    chk("t5_oe_idle", 8'(o_miso_oe), 8'h00);
    ss_end();
    ss_start();
    chk("t5_oe_new_frame", 8'(o_miso_oe), 8'h01);
    ss_end();
    bus_write(1'b0, 8'h18);
    bus_read(1'b0, rd); chk("t5_status_restored", rd, 8'h12);

    // host read coincides with completion of a second byte
    ss_start();
    xfer(8'hC3, mo);
    xfer_read_at_end(8'h3A, rd);
    chk("t6_read_old", rd, 8'hC3);
    ss_end();
    bus_read(1'b0, rd); chk("t6_full_no_ovr", rd & 8'h05, 8'h01);
    bus_read(1'b1, rd); chk("t6_rxdata_new", rd, 8'h3A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
